// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM generator and the PWM demodulator.
//   FRAME_W_DEF    - default log2 of the carrier frame length in clocks
//   demod_state_e  - demodulator FSM state encoding
//   offset_to_twos - offset-binary <-> two's-complement conversion (widths up to 16)
package pwm_pkg;

    localparam int unsigned FRAME_W_DEF = 8;

    typedef enum logic [1:0] {
        StAcq,
        StRun,
        StLost
    } demod_state_e;

    // Flipping the MSB maps offset binary to two's complement and back.
    function automatic logic [15:0] offset_to_twos(input logic [15:0] val,
                                                   input int unsigned width);
        return val ^ (16'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: multi-stage synchroniser for an asynchronous single-bit input, plus a
// toggle detector on the synchronised signal.
//   clk_100m  in   system clock
//   rst       in   synchronous active-high reset; clears every stage
//   pwm_i     in   asynchronous input
//   pwm_s     out  synchronised input (SYNC_STG flops after pwm_i)
//   pwm_edge  out  high for one cycle whenever pwm_s differs from its previous value
// SYNC_STG must be at least 2.
module pwm_edge_sync #(
    parameter int unsigned SYNC_STG = 2
) (
    input  logic clk_100m,
    input  logic rst,
    input  logic pwm_i,
    output logic pwm_s,
    output logic pwm_edge
);

    logic [SYNC_STG-1:0] sync_q;
    logic                pwm_d;

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            sync_q <= '0;
            pwm_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], pwm_i};
            pwm_d  <= pwm_s;
        end
    end

    assign pwm_s    = sync_q[SYNC_STG-1];
    assign pwm_edge = pwm_s ^ pwm_d;

endmodule

// File: rtl/pwm_demod.sv
// pwm_demod: measures the high time of a PWM stream over every 2^FRAME_W-cycle carrier
// frame and emits it as a signed sample.
//   clk_100m  in   system clock
//   rst       in   synchronous active-high reset
//   pwm_i     in   asynchronous PWM stream
//   data_o    out  demodulated sample, two's complement
//   data_vld  out  one-cycle strobe marking a new data_o
//   sig_lost  out  high while pwm_i shows no edges
// Build option PWM_DEMOD_FILT_EN: inserts a 4-tap moving average before conversion, which
// delays data_vld (and the sig_lost rise) by one cycle.
module pwm_demod
    import pwm_pkg::*;
#(
    parameter int unsigned FRAME_W     = FRAME_W_DEF,
    parameter int unsigned SYNC_STG    = 2,
    parameter int unsigned LOST_FRAMES = 2
) (
    input  logic               clk_100m,
    input  logic               rst,
    input  logic               pwm_i,
    output logic [FRAME_W-1:0] data_o,
    output logic               data_vld,
    output logic               sig_lost
);

    localparam int unsigned LF_W = $clog2(LOST_FRAMES + 1);

    demod_state_e       state;
    logic               pwm_s;
    logic               pwm_edge;
    logic [FRAME_W-1:0] frame_cnt;
    logic               frame_end;
    logic [FRAME_W:0]   high_acc;
    logic [FRAME_W:0]   duty_raw;
    logic [FRAME_W-1:0] duty_sat;
    logic               edge_seen_q;
    logic [LF_W-1:0]    idle_cnt;
    logic [LF_W-1:0]    idle_cnt_nxt;
    logic               idle_hit;
    logic               emit;
    logic               lost_rise;
    logic               to_acq;

    // Output-stage controls, with or without the filter stage in between.
    logic               out_vld_set;
    logic [FRAME_W-1:0] out_sample;
    logic               lost_set;

    pwm_edge_sync #(
        .SYNC_STG (SYNC_STG)
    ) u_sync (
        .clk_100m (clk_100m),
        .rst      (rst),
        .pwm_i    (pwm_i),
        .pwm_s    (pwm_s),
        .pwm_edge (pwm_edge)
    );

    assign frame_end = (frame_cnt == '1);

    // The final cycle's sample is folded in here so the accumulator can restart at once.
    assign duty_raw = high_acc + (FRAME_W + 1)'(pwm_s);
    assign duty_sat = duty_raw[FRAME_W] ? '1 : duty_raw[FRAME_W-1:0];

    always_comb begin
        idle_cnt_nxt = idle_cnt;
        if (pwm_edge) begin
            idle_cnt_nxt = '0;
        end else if (frame_end && !edge_seen_q && (idle_cnt != LF_W'(LOST_FRAMES))) begin
            idle_cnt_nxt = idle_cnt + LF_W'(1);
        end
    end

    assign idle_hit  = frame_end && (idle_cnt_nxt == LF_W'(LOST_FRAMES));
    // An edge in LOST wins over a coincident frame-end.
    assign to_acq    = (state == StLost) && pwm_edge;
    assign emit      = frame_end && ((state == StRun) || ((state == StLost) && !pwm_edge));
    assign lost_rise = (state == StRun) && idle_hit;

`ifdef PWM_DEMOD_FILT_EN
    logic [FRAME_W-1:0] hist_q [4];
    logic               hist_vld_q;
    logic               emit_q;
    logic               lost_rise_q;
    logic [FRAME_W+1:0] filt_sum;

    assign filt_sum = (FRAME_W + 2)'(hist_q[0]) + (FRAME_W + 2)'(hist_q[1])
                    + (FRAME_W + 2)'(hist_q[2]) + (FRAME_W + 2)'(hist_q[3]);

    always_ff @(posedge clk_100m) begin
        if (rst || to_acq) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
            hist_vld_q <= 1'b0;
        end else if (emit) begin
            // First sample after acquisition primes every tap.
            hist_q[0] <= duty_sat;
            for (int i = 1; i < 4; i++) begin
                hist_q[i] <= hist_vld_q ? hist_q[i-1] : duty_sat;
            end
            hist_vld_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            emit_q      <= 1'b0;
            lost_rise_q <= 1'b0;
        end else begin
            emit_q      <= emit;
            lost_rise_q <= lost_rise;
        end
    end

    assign out_vld_set = emit_q;
    assign out_sample  = filt_sum[FRAME_W+1:2];
    assign lost_set    = lost_rise_q;
`else
    assign out_vld_set = emit;
    assign out_sample  = duty_sat;
    assign lost_set    = lost_rise;
`endif

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state       <= StAcq;
            frame_cnt   <= '0;
            high_acc    <= '0;
            edge_seen_q <= 1'b0;
            idle_cnt    <= '0;
            data_o      <= '0;
            data_vld    <= 1'b0;
            sig_lost    <= 1'b0;
        end else begin
            frame_cnt   <= frame_cnt + FRAME_W'(1);
            high_acc    <= frame_end ? '0 : duty_raw;
            edge_seen_q <= frame_end ? 1'b0 : (edge_seen_q | pwm_edge);
            idle_cnt    <= idle_cnt_nxt;

            data_vld <= out_vld_set;
            if (out_vld_set) begin
                data_o <= FRAME_W'(offset_to_twos(16'(out_sample), FRAME_W));
            end

            // Clear after set so a recovering edge always wins.
            if (lost_set) begin
                sig_lost <= 1'b1;
            end
            if (to_acq) begin
                sig_lost <= 1'b0;
            end

            unique case (state)
                StAcq: begin
                    if (frame_end) begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (lost_rise) begin
                        state <= StLost;
                    end
                end
                StLost: begin
                    if (to_acq) begin
                        state <= StAcq;
                    end
                end
                default: state <= StAcq;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod: directed self-checking bench for pwm_demod (default build, FRAME_W = 8).
module tb_pwm_demod;

    logic       clk_100m = 1'b0;
    logic       rst;
    logic       pwm_i;
    logic [7:0] data_o;
    logic       data_vld;
    logic       sig_lost;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   duty_cfg = 128;
    int   vld_cyc;
    int   edge_cyc;
    logic lost_prev;

    pwm_demod #(
        .FRAME_W     (8),
        .SYNC_STG    (2),
        .LOST_FRAMES (2)
    ) dut (
        .clk_100m (clk_100m),
        .rst      (rst),
        .pwm_i    (pwm_i),
        .data_o   (data_o),
        .data_vld (data_vld),
        .sig_lost (sig_lost)
    );

    always #5 clk_100m = ~clk_100m;

    // Drive one cycle of the PWM pattern (high for duty_cfg cycles of each 256) and
    // return 1 time unit after the next rising edge.
    task automatic tick();
        pwm_i = ((cyc % 256) < duty_cfg);
        @(posedge clk_100m);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next data_vld strobe; reports its cycle and the sig_lost value
    // seen in the cycle just before it.
    task automatic wait_vld(output int at_cyc, output logic lost_before);
        int budget;
        budget      = 0;
        lost_before = sig_lost;
        tick();
        while (data_vld !== 1'b1 && budget < 700) begin
            lost_before = sig_lost;
            tick();
            budget++;
        end
        check("vld_seen", 32'(data_vld), 32'd1);
        at_cyc = cyc;
    endtask

    initial begin
        rst   = 1'b1;
        pwm_i = 1'b0;
        repeat (4) tick();
        check("rst_data", 32'(data_o), 32'h00);
        check("rst_vld", 32'(data_vld), 32'd0);
        check("rst_lost", 32'(sig_lost), 32'd0);

        // 50% duty; first frame is discarded, first strobe at cycle 512.
        rst = 1'b0;
        cyc = 0;
        wait_vld(vld_cyc, lost_prev);
        check("first_vld_cyc", 32'(vld_cyc), 32'd512);
        check("duty128_data", 32'(data_o), 32'h00);
        tick();
        check("strobe_one_cycle", 32'(data_vld), 32'd0);
        wait_vld(vld_cyc, lost_prev);
        check("second_vld_cyc", 32'(vld_cyc), 32'd768);
        check("duty128_data2", 32'(data_o), 32'h00);

        // Duty sweep: skip the transition frame, check the next.
        duty_cfg = 64;
        wait_vld(vld_cyc, lost_prev);
        wait_vld(vld_cyc, lost_prev);
        check("duty64_data", 32'(data_o), 32'hC0);

        duty_cfg = 192;
        wait_vld(vld_cyc, lost_prev);
        wait_vld(vld_cyc, lost_prev);
        check("duty192_data", 32'(data_o), 32'h40);

        duty_cfg = 256;
        wait_vld(vld_cyc, lost_prev);
        wait_vld(vld_cyc, lost_prev);
        check("duty256_sat_data", 32'(data_o), 32'h7F);
        check("duty256_not_lost", 32'(sig_lost), 32'd0);

        // Falling to 0: the transition frame still holds two high cycles.
        duty_cfg = 0;
        wait_vld(vld_cyc, lost_prev);
        check("duty0_transition", 32'(data_o), 32'h82);
        wait_vld(vld_cyc, lost_prev);
        check("duty0_data", 32'(data_o), 32'h80);
        check("idle1_not_lost", 32'(sig_lost), 32'd0);
        wait_vld(vld_cyc, lost_prev);
        check("lost_before_vld", 32'(lost_prev), 32'd0);
        check("lost_with_vld", 32'(sig_lost), 32'd1);
        check("lost_data", 32'(data_o), 32'h80);

        // Single rising edge mid-frame while lost.
        while ((cyc % 256) != 100) tick();
        edge_cyc = cyc;
        duty_cfg = 256;
        tick();
        tick();
        check("lost_at_edge", 32'(sig_lost), 32'd1);
        tick();
        check("lost_fall", 32'(sig_lost), 32'd0);
        wait_vld(vld_cyc, lost_prev);
        check("reacq_vld_cyc", 32'(vld_cyc), 32'((edge_cyc / 256 + 2) * 256));
        check("reacq_data", 32'(data_o), 32'h7F);
        check("reacq_not_lost", 32'(sig_lost), 32'd0);

        // Reset in the middle of a frame.
        while ((cyc % 256) != 100) tick();
        check("pre_rst_data", 32'(data_o), 32'h7F);
        duty_cfg = 192;
        rst      = 1'b1;
        tick();
        check("midrst_data", 32'(data_o), 32'h00);
        check("midrst_vld", 32'(data_vld), 32'd0);
        check("midrst_lost", 32'(sig_lost), 32'd0);
        rst = 1'b0;
        cyc = 0;
        wait_vld(vld_cyc, lost_prev);
        check("post_rst_vld_cyc", 32'(vld_cyc), 32'd512);
        check("post_rst_data", 32'(data_o), 32'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
